// File: rtl/decrypt_2blocks_128.sv
// ---------------------------------------------------------------------------
// decrypt_2blocks_128
// Ascon-128 authenticated decryption of one associated-data block and one
// ciphertext block. One permutation round is computed per clock. The
// plaintext is released only when the recomputed tag matches the received one.
//
// Ports
//   CLK      in   1    clock, rising edge
//   RST      in   1    asynchronous active-low reset
//   START    in   1    request, sampled only while BUSY=0
//   SK       in 128    secret key (bit 127 = first byte)
//   N        in 128    nonce
//   A        in  64    associated data block (bit 63 = first byte)
//   C        in  64    ciphertext block
//   T        in 128    received tag
//   BUSY     out  1    operation in progress
//   DONE     out  1    one-cycle pulse, results valid
//   P        out 64    recovered plaintext, zero unless AUTH_OK
//   AUTH_OK  out  1    tag matched; held with P until the next accepted START
// ---------------------------------------------------------------------------
module decrypt_2blocks_128 #(
   parameter logic [63:0] IV       = 64'h80400c0600000000,
   parameter int          ROUNDS_A = 12,
   parameter int          ROUNDS_B = 6
) (
   input  logic         CLK,
   input  logic         RST,
   input  logic         START,
   input  logic [127:0] SK,
   input  logic [127:0] N,
   input  logic [63:0]  A,
   input  logic [63:0]  C,
   input  logic [127:0] T,
   output logic         BUSY,
   output logic         DONE,
   output logic [63:0]  P,
   output logic         AUTH_OK
);

   localparam logic [63:0] PAD = 64'h8000000000000000;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_INIT   = 3'd1,
      ST_AD1    = 3'd2,
      ST_AD2    = 3'd3,
      ST_CT     = 3'd4,
      ST_FINAL  = 3'd5,
      ST_VERIFY = 3'd6
   } state_t;

   // One Ascon round: constant addition on x2, bitsliced 5-bit S-box,
   // then the per-word linear diffusion layer.
   function automatic logic [319:0] ascon_round(input logic [319:0] s,
                                                input logic [7:0]   rc);
      logic [63:0] x0, x1, x2, x3, x4;
      logic [63:0] t0, t1, t2, t3, t4;
      x0 = s[319:256];
      x1 = s[255:192];
      x2 = s[191:128] ^ {56'd0, rc};
      x3 = s[127:64];
      x4 = s[63:0];
      x0 = x0 ^ x4;
      x4 = x4 ^ x3;
      x2 = x2 ^ x1;
      t0 = ~x0 & x1;
      t1 = ~x1 & x2;
      t2 = ~x2 & x3;
      t3 = ~x3 & x4;
      t4 = ~x4 & x0;
      x0 = x0 ^ t1;
      x1 = x1 ^ t2;
      x2 = x2 ^ t3;
      x3 = x3 ^ t4;
      x4 = x4 ^ t0;
      x1 = x1 ^ x0;
      x0 = x0 ^ x4;
      x3 = x3 ^ x2;
      x2 = ~x2;
      x0 = x0 ^ {x0[18:0], x0[63:19]} ^ {x0[27:0], x0[63:28]};
      x1 = x1 ^ {x1[60:0], x1[63:61]} ^ {x1[38:0], x1[63:39]};
      x2 = x2 ^ {x2[0],    x2[63:1]}  ^ {x2[5:0],  x2[63:6]};
      x3 = x3 ^ {x3[9:0],  x3[63:10]} ^ {x3[16:0], x3[63:17]};
      x4 = x4 ^ {x4[6:0],  x4[63:7]}  ^ {x4[40:0], x4[63:41]};
      return {x0, x1, x2, x3, x4};
   endfunction

   state_t         state_r;
   logic [319:0]   s_r;
   logic [3:0]     cnt_r;
   logic [127:0]   key_r;
   logic [63:0]    a_r;
   logic [63:0]    c_r;
   logic [127:0]   tag_r;
   logic [63:0]    pc_r;

   logic           long_s;
   logic           last_s;
   logic [3:0]     idx_s;
   logic [7:0]     rc_s;
   logic [319:0]   rnd_s;
   logic [319:0]   nxt_s;
   logic [63:0]    pc_nxt_s;
   state_t         succ_s;
   logic [127:0]   tc_s;
   logic           tag_ok_s;

   // Round schedule: p^12 uses constant indices 0..11, p^6 uses 6..11.
   always_comb begin
      long_s = (state_r == ST_INIT) || (state_r == ST_FINAL);
      if (long_s) begin
         last_s = (cnt_r == 4'(ROUNDS_A - 1));
         idx_s  = cnt_r;
      end else begin
         last_s = (cnt_r == 4'(ROUNDS_B - 1));
         idx_s  = cnt_r + 4'(ROUNDS_A - ROUNDS_B);
      end
      rc_s  = 8'hf0 - ({4'd0, idx_s} * 8'h0f);
      rnd_s = ascon_round(s_r, rc_s);
   end

   // Phase successor and the state injections applied after each phase's last round.
   always_comb begin
      nxt_s    = rnd_s;
      pc_nxt_s = 64'd0;
      succ_s   = ST_IDLE;
      case (state_r)
         ST_INIT: begin
            succ_s = ST_AD1;
            if (last_s) begin
               nxt_s[127:0]   = rnd_s[127:0] ^ key_r;
               nxt_s[319:256] = rnd_s[319:256] ^ a_r;
            end else begin
               nxt_s = rnd_s;
            end
         end
         ST_AD1: begin
            succ_s = ST_AD2;
            if (last_s) begin
               nxt_s[319:256] = rnd_s[319:256] ^ PAD;
            end else begin
               nxt_s = rnd_s;
            end
         end
         ST_AD2: begin
            succ_s = ST_CT;
            if (last_s) begin
               // Domain separation, then the ciphertext replaces the rate word.
               nxt_s[0]       = ~rnd_s[0];
               pc_nxt_s       = rnd_s[319:256] ^ c_r;
               nxt_s[319:256] = c_r;
            end else begin
               nxt_s = rnd_s;
            end
         end
         ST_CT: begin
            succ_s = ST_FINAL;
            if (last_s) begin
               nxt_s[319:256] = rnd_s[319:256] ^ PAD;
               nxt_s[255:192] = rnd_s[255:192] ^ key_r[127:64];
               nxt_s[191:128] = rnd_s[191:128] ^ key_r[63:0];
            end else begin
               nxt_s = rnd_s;
            end
         end
         ST_FINAL: begin
            succ_s = ST_VERIFY;
         end
         default: begin
            succ_s = ST_IDLE;
         end
      endcase
   end

   // Recomputed tag and full-width comparison against the latched tag.
   always_comb begin
      tc_s     = {s_r[127:64] ^ key_r[127:64], s_r[63:0] ^ key_r[63:0]};
      tag_ok_s = (tc_s == tag_r);
   end

   // Control FSM, state register and registered outputs.
   // The tag compare gets its own cycle (ST_VERIFY) after the final round,
   // which places DONE 43 cycles after the accept edge.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_r <= ST_IDLE;
         s_r     <= 320'd0;
         cnt_r   <= 4'd0;
         key_r   <= 128'd0;
         a_r     <= 64'd0;
         c_r     <= 64'd0;
         tag_r   <= 128'd0;
         pc_r    <= 64'd0;
         BUSY    <= 1'b0;
         DONE    <= 1'b0;
         P       <= 64'd0;
         AUTH_OK <= 1'b0;
      end else begin
         DONE <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (START) begin
                  key_r   <= SK;
                  a_r     <= A;
                  c_r     <= C;
                  tag_r   <= T;
                  s_r     <= {IV, SK, N};
                  cnt_r   <= 4'd0;
                  P       <= 64'd0;
                  AUTH_OK <= 1'b0;
                  BUSY    <= 1'b1;
                  state_r <= ST_INIT;
               end else begin
                  BUSY    <= 1'b0;
                  state_r <= ST_IDLE;
               end
            end
            ST_INIT, ST_AD1, ST_AD2, ST_CT, ST_FINAL: begin
               s_r <= nxt_s;
               if (last_s) begin
                  cnt_r   <= 4'd0;
                  state_r <= succ_s;
               end else begin
                  cnt_r   <= cnt_r + 4'd1;
               end
               if ((state_r == ST_AD2) && last_s) begin
                  pc_r <= pc_nxt_s;
               end else begin
                  pc_r <= pc_r;
               end
            end
            ST_VERIFY: begin
               AUTH_OK <= tag_ok_s;
               P       <= tag_ok_s ? pc_r : 64'd0;
               pc_r    <= 64'd0;
               DONE    <= 1'b1;
               BUSY    <= 1'b0;
               state_r <= ST_IDLE;
            end
            default: begin
               BUSY    <= 1'b0;
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_decrypt_2blocks_128.sv
// ---------------------------------------------------------------------------
// tb_decrypt_2blocks_128
// Scoreboard bench: an independent table-driven Ascon encryptor produces C/T
// for directed vectors; the stimulus side queues the expected plaintext, tag
// verdict and accept cycle, and a monitor checks every DONE pulse.
// ---------------------------------------------------------------------------
module tb_decrypt_2blocks_128;

   localparam logic [63:0] IV_C  = 64'h80400c0600000000;
   localparam logic [63:0] PAD_C = 64'h8000000000000000;

   logic         CLK;
   logic         RST;
   logic         START;
   logic [127:0] SK;
   logic [127:0] N;
   logic [63:0]  A;
   logic [63:0]  C;
   logic [127:0] T;
   logic         BUSY;
   logic         DONE;
   logic [63:0]  P;
   logic         AUTH_OK;

   decrypt_2blocks_128 dut (
      .CLK(CLK), .RST(RST), .START(START), .SK(SK), .N(N), .A(A), .C(C), .T(T),
      .BUSY(BUSY), .DONE(DONE), .P(P), .AUTH_OK(AUTH_OK)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct {
      logic [63:0] p;
      logic        auth;
      int          acc;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;
   int   checks   = 0;
   int   errors   = 0;
   int   cyc      = 0;
   int   done_cnt = 0;
   logic prev_done = 1'b0;

   always @(posedge CLK) cyc <= cyc + 1;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // Reference S-box as a lookup table (input x0 is the MSB).
   function automatic logic [4:0] sbox(input logic [4:0] v);
      case (v)
         5'h00: return 5'h04;  5'h01: return 5'h0b;  5'h02: return 5'h1f;  5'h03: return 5'h14;
         5'h04: return 5'h1a;  5'h05: return 5'h15;  5'h06: return 5'h09;  5'h07: return 5'h02;
         5'h08: return 5'h1b;  5'h09: return 5'h05;  5'h0a: return 5'h08;  5'h0b: return 5'h12;
         5'h0c: return 5'h1d;  5'h0d: return 5'h03;  5'h0e: return 5'h06;  5'h0f: return 5'h1c;
         5'h10: return 5'h1e;  5'h11: return 5'h13;  5'h12: return 5'h07;  5'h13: return 5'h0e;
         5'h14: return 5'h00;  5'h15: return 5'h0d;  5'h16: return 5'h11;  5'h17: return 5'h18;
         5'h18: return 5'h10;  5'h19: return 5'h0c;  5'h1a: return 5'h01;  5'h1b: return 5'h19;
         5'h1c: return 5'h16;  5'h1d: return 5'h0a;  5'h1e: return 5'h0f;  default: return 5'h17;
      endcase
   endfunction

   function automatic logic [63:0] rotr(input logic [63:0] v, input int n);
      return (v >> n) | (v << (64 - n));
   endfunction

   function automatic logic [319:0] perm(input logic [319:0] s, input int nr);
      logic [63:0] x [5];
      logic [4:0]  col;
      for (int w = 0; w < 5; w++) x[w] = s[319 - 64*w -: 64];
      for (int r = 12 - nr; r < 12; r++) begin
         x[2] = x[2] ^ {56'd0, 4'(15 - r), 4'(r)};
         for (int b = 0; b < 64; b++) begin
            col = sbox({x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]});
            {x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]} = col;
         end
         x[0] = x[0] ^ rotr(x[0], 19) ^ rotr(x[0], 28);
         x[1] = x[1] ^ rotr(x[1], 61) ^ rotr(x[1], 39);
         x[2] = x[2] ^ rotr(x[2], 1)  ^ rotr(x[2], 6);
         x[3] = x[3] ^ rotr(x[3], 10) ^ rotr(x[3], 17);
         x[4] = x[4] ^ rotr(x[4], 7)  ^ rotr(x[4], 41);
      end
      return {x[0], x[1], x[2], x[3], x[4]};
   endfunction

   // Encryptor counterpart: produces C and T from a known plaintext.
   task automatic enc(input logic [127:0] k, input logic [127:0] n, input logic [63:0] a,
                      input logic [63:0] pt, output logic [63:0] c, output logic [127:0] t);
      logic [319:0] s;
      s = perm({IV_C, k, n}, 12);
      s[127:0]   = s[127:0] ^ k;
      s[319:256] = s[319:256] ^ a;
      s = perm(s, 6);
      s[319:256] = s[319:256] ^ PAD_C;
      s = perm(s, 6);
      s[0] = ~s[0];
      c = s[319:256] ^ pt;
      s[319:256] = c;
      s = perm(s, 6);
      s[319:256] = s[319:256] ^ PAD_C;
      s[255:128] = s[255:128] ^ k;
      s = perm(s, 12);
      t = s[127:0] ^ k;
   endtask

   // Monitor: every DONE pulse pops one expectation.
   always @(negedge CLK) begin
      if (prev_done === 1'b1) check("done_single_pulse", {127'd0, DONE}, 128'd0);
      prev_done <= DONE;
      if (DONE === 1'b1) begin
         done_cnt <= done_cnt + 1;
         if (sb_q.size() == 0) begin
            check("unexpected_done", 128'd1, 128'd0);
         end else begin
            mon_e = sb_q.pop_front();
            check("p",        {64'd0, P},           {64'd0, mon_e.p});
            check("auth_ok",  {127'd0, AUTH_OK},    {127'd0, mon_e.auth});
            check("latency",  128'(cyc - mon_e.acc), 128'd43);
            check("busy_low_at_done", {127'd0, BUSY}, 128'd0);
         end
      end
   end

   task automatic wait_dones(input int target, input int budget);
      int i;
      for (i = 0; i < budget; i++) begin
         @(negedge CLK);
         if (done_cnt >= target) break;
      end
      if (i >= budget) check("done_timeout", 128'(done_cnt), 128'(target));
   endtask

   task automatic run(input logic [127:0] k, input logic [127:0] n, input logic [63:0] a,
                      input logic [63:0] c, input logic [127:0] t,
                      input logic [63:0] p_req, input logic auth_req, input bit scramble);
      int base;
      base = done_cnt;
      @(negedge CLK);
      SK = k; N = n; A = a; C = c; T = t; START = 1'b1;
      sb_q.push_back('{p: p_req, auth: auth_req, acc: cyc + 1});
      @(negedge CLK);
      START = 1'b0;
      check("busy_after_accept", {127'd0, BUSY}, 128'd1);
      if (scramble) begin
         repeat (4) @(negedge CLK);
         SK = {$urandom, $urandom, $urandom, $urandom};
         N  = {$urandom, $urandom, $urandom, $urandom};
         A  = {$urandom, $urandom};
         C  = {$urandom, $urandom};
         T  = {$urandom, $urandom, $urandom, $urandom};
      end
      wait_dones(base + 1, 100);
      repeat (2) @(negedge CLK);
   endtask

   initial begin
      logic [127:0] k0, n0, k1, n1, t0, t1, tz;
      logic [63:0]  a0, p0, c0, a1, p1, c1, cz;
      int base;

      RST = 1'b0; START = 1'b0;
      SK = 128'd0; N = 128'd0; A = 64'd0; C = 64'd0; T = 128'd0;
      #12;
      check("reset_busy", {127'd0, BUSY},    128'd0);
      check("reset_done", {127'd0, DONE},    128'd0);
      check("reset_p",    {64'd0, P},        128'd0);
      check("reset_auth", {127'd0, AUTH_OK}, 128'd0);
      @(negedge CLK);
      RST = 1'b1;

      k0 = 128'h000102030405060708090A0B0C0D0E0F;
      n0 = 128'h000102030405060708090A0B0C0D0E0F;
      a0 = 64'h0001020304050607;
      p0 = 64'h0001020304050607;
      enc(k0, n0, a0, p0, c0, t0);

      // Round trip, then single-bit tampering of T, C and A.
      run(k0, n0, a0, c0, t0,                     p0,    1'b1, 1'b0);
      run(k0, n0, a0, c0, t0 ^ 128'd1,            64'd0, 1'b0, 1'b0);
      run(k0, n0, a0, c0 ^ 64'h8000000000000000, t0, 64'd0, 1'b0, 1'b0);
      run(k0, n0, a0 ^ 64'd1, c0, t0,             64'd0, 1'b0, 1'b0);
      // Inputs scrambled a few cycles after accept must not matter.
      run(k0, n0, a0, c0, t0,                     p0,    1'b1, 1'b1);

      // START held for 100 cycles: accepts at +0, +44, +88.
      base = done_cnt;
      @(negedge CLK);
      SK = k0; N = n0; A = a0; C = c0; T = t0; START = 1'b1;
      for (int j = 0; j < 3; j++) sb_q.push_back('{p: p0, auth: 1'b1, acc: cyc + 1 + 44*j});
      repeat (100) @(negedge CLK);
      START = 1'b0;
      wait_dones(base + 3, 200);
      repeat (2) @(negedge CLK);

      // Reset during a run: outputs clear asynchronously and no DONE follows.
      base = done_cnt;
      @(negedge CLK);
      SK = k0; N = n0; A = a0; C = c0; T = t0; START = 1'b1;
      @(negedge CLK);
      START = 1'b0;
      repeat (18) @(negedge CLK);
      check("busy_before_abort", {127'd0, BUSY}, 128'd1);
      #2 RST = 1'b0;
      #1;
      check("abort_busy", {127'd0, BUSY},    128'd0);
      check("abort_done", {127'd0, DONE},    128'd0);
      check("abort_p",    {64'd0, P},        128'd0);
      check("abort_auth", {127'd0, AUTH_OK}, 128'd0);
      repeat (3) @(negedge CLK);
      RST = 1'b1;
      repeat (60) @(negedge CLK);
      check("no_done_after_abort", 128'(done_cnt), 128'(base));

      // Fresh vector after the abort.
      k1 = 128'h0F0E0D0C0B0A09080706050403020100;
      n1 = 128'h1122334455667788_99AABBCCDDEEFF00;
      a1 = 64'hA5A5A5A55A5A5A5A;
      p1 = 64'hDEADBEEFCAFEF00D;
      enc(k1, n1, a1, p1, c1, t1);
      run(k1, n1, a1, c1, t1, p1, 1'b1, 1'b0);

      // All-zero key, nonce, AD and plaintext.
      enc(128'd0, 128'd0, 64'd0, 64'd0, cz, tz);
      run(128'd0, 128'd0, 64'd0, cz, tz, 64'd0, 1'b1, 1'b0);

      repeat (5) @(negedge CLK);
      check("scoreboard_empty", 128'(sb_q.size()), 128'd0);
      check("done_total",       128'(done_cnt),    128'd10);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

endmodule
